// File: rtl/ipgu_window_scanner.sv
// Window scanner: walks WIN x WIN windows over an image held in RAM
// and streams each window to the consumer as BEAT_ROWS-row beats.
module ipgu_window_scanner #(
  parameter int PIX_W     = 8,
  parameter int IMG_W     = 300,
  parameter int IMG_H     = 300,
  parameter int WIN       = 20,
  parameter int BEAT_ROWS = 4,
  parameter int STRIDE_W  = 5,
  parameter int ADDR_W    = $clog2(IMG_W*IMG_H)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init,
  input  logic [STRIDE_W-1:0]              stride,
  output logic                             rdy,
  output logic                             ram_rd_en,
  output logic [ADDR_W-1:0]                ram_addr,
  input  logic [PIX_W-1:0]                 ram_rd_data,
  input  logic                             out_rdy,
  output logic                             out_vld,
  output logic [BEAT_ROWS*WIN*PIX_W-1:0]   out_data,
  output logic [((WIN/BEAT_ROWS) > 1 ?
                 $clog2(WIN/BEAT_ROWS) : 1)-1:0] out_beat,
  output logic [$clog2(IMG_W)-1:0]         out_win_x,
  output logic [$clog2(IMG_H)-1:0]         out_win_y,
  output logic                             out_last,
  output logic                             done
);

  localparam int NB   = WIN / BEAT_ROWS;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int NPIX = BEAT_ROWS * WIN;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int RW   = (BEAT_ROWS > 1) ? $clog2(BEAT_ROWS) : 1;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int DW   = NPIX * PIX_W;
  localparam int AW1  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [STRIDE_W-1:0] stride_q;
  logic [XW-1:0]       win_x;
  logic [YW-1:0]       win_y;
  logic [BW-1:0]       beat;
  logic [RW-1:0]       rd_r;
  logic [CW-1:0]       rd_c;
  logic [IW-1:0]       rd_idx;
  logic [IW-1:0]       wr_idx;
  logic                wr_en;
  logic [DW-1:0]       buffer;

  logic [31:0]    nx;
  logic [31:0]    ny;
  logic           x_adv;
  logic           y_adv;
  logic           last_beat;
  logic           run_end;
  logic           rd_last;
  logic           hs;
  logic [AW1-1:0] row_a;
  logic [AW1-1:0] addr_full;

  assign nx        = 32'(win_x) + 32'(stride_q);
  assign ny        = 32'(win_y) + 32'(stride_q);
  assign x_adv     = nx <= 32'(IMG_W - WIN);
  assign y_adv     = ny <= 32'(IMG_H - WIN);
  assign last_beat = beat == BW'(NB - 1);
  assign run_end   = last_beat && !x_adv && !y_adv;
  assign rd_last   = rd_idx == IW'(NPIX - 1);
  assign hs        = (state == S_PRESENT) && out_rdy;

  assign row_a     = AW1'(win_y) + AW1'(beat) * AW1'(BEAT_ROWS)
                   + AW1'(rd_r);
  assign addr_full = row_a * AW1'(IMG_W) + AW1'(win_x) + AW1'(rd_c);

  assign rdy       = state == S_IDLE;
  assign ram_rd_en = state == S_FETCH;
  assign ram_addr  = ram_rd_en ? ADDR_W'(addr_full) : '0;
  assign out_vld   = state == S_PRESENT;
  assign done      = state == S_DONE;
  assign out_last  = out_vld && run_end;
  assign out_data  = buffer;
  assign out_beat  = beat;
  assign out_win_x = win_x;
  assign out_win_y = win_y;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (init) state_n = S_FETCH;
      S_FETCH:   if (rd_last) state_n = S_WAIT_RD;
      S_WAIT_RD: state_n = S_PRESENT;
      S_PRESENT: if (out_rdy) state_n = run_end ? S_DONE : S_FETCH;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Window position, beat index and stride for the current run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q <= '0;
      win_x    <= '0;
      win_y    <= '0;
      beat     <= '0;
    end else if (state == S_IDLE && init) begin
      stride_q <= (stride == '0) ? STRIDE_W'(1) : stride;
      win_x    <= '0;
      win_y    <= '0;
      beat     <= '0;
    end else if (hs) begin
      if (!last_beat) begin
        beat <= beat + 1'b1;
      end else begin
        beat <= '0;
        if (x_adv) begin
          win_x <= XW'(nx);
        end else if (y_adv) begin
          win_x <= '0;
          win_y <= YW'(ny);
        end
      end
    end
  end

  // Read cursor within the beat, row-major
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r   <= '0;
      rd_c   <= '0;
      rd_idx <= '0;
    end else if (state == S_FETCH) begin
      if (rd_last) begin
        rd_r   <= '0;
        rd_c   <= '0;
        rd_idx <= '0;
      end else begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_c == CW'(WIN - 1)) begin
          rd_c <= '0;
          rd_r <= rd_r + 1'b1;
        end else begin
          rd_c <= rd_c + 1'b1;
        end
      end
    end
  end

  // RAM data lands one cycle after its read; track the slot it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en  <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_en  <= state == S_FETCH;
      wr_idx <= rd_idx;
    end
  end

  // Beat buffer fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
    end else if (wr_en) begin
      buffer[int'(wr_idx)*PIX_W +: PIX_W] <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_ipgu_window_scanner.sv
// Scoreboard bench for the window scanner on an 8x6 image,
// 4x4 windows, 2-row beats, RAM[a] = a.
module tb_ipgu_window_scanner;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WN = 4;
  localparam int BR = 2;
  localparam int PW = 8;
  localparam int SW = 5;
  localparam int AW = $clog2(W*H);
  localparam int DW = BR*WN*PW;
  localparam int NB = WN/BR;

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic [SW-1:0] stride;
  logic          rdy;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [PW-1:0] ram_rd_data = '0;
  logic          out_rdy;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic [0:0]    out_beat;
  logic [2:0]    out_win_x;
  logic [2:0]    out_win_y;
  logic          out_last;
  logic          done;

  ipgu_window_scanner #(
    .PIX_W(PW), .IMG_W(W), .IMG_H(H), .WIN(WN),
    .BEAT_ROWS(BR), .STRIDE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .stride(stride),
    .rdy(rdy), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data), .out_rdy(out_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_beat(out_beat),
    .out_win_x(out_win_x), .out_win_y(out_win_y),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= 8'(ram_addr);
  end

  typedef struct packed {
    logic [2:0]    x;
    logic [2:0]    y;
    logic [0:0]    b;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int pops = 0;
  int dones = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  logic last_seen = 1'b0;
  logic [DW-1:0] first_data = '0;
  logic [DW-1:0] last_data = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_vld && out_rdy) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: x=%0d y=%0d b=%0d data=%h, no beat required",
                 out_win_x, out_win_y, out_beat, out_data);
      end else begin
        e = q.pop_front();
        if ({out_win_x, out_win_y, out_beat, out_data, out_last} !==
            {e.x, e.y, e.b, e.d, e.l}) begin
          fails++;
          $display("FAIL beat: got x=%0d y=%0d b=%0d last=%0d data=%h, required x=%0d y=%0d b=%0d last=%0d data=%h",
                   out_win_x, out_win_y, out_beat, out_last, out_data,
                   e.x, e.y, e.b, e.l, e.d);
        end
      end
      pops++;
      if (pops == 1) first_data = out_data;
      last_data   = out_data;
      last_seen   = out_last;
      last_hs_cyc = cyc;
    end
    if (!rst && done) begin
      tests++;
      dones++;
      if (!(last_seen && cyc == last_hs_cyc + 1)) begin
        fails++;
        $display("FAIL done_timing: done at cycle %0d last=%0d, required 1 cycle after final beat at %0d",
                 cyc, last_seen, last_hs_cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic void push_run(input int s);
    int st;
    exp_t e;
    st = (s == 0) ? 1 : s;
    for (int y = 0; y <= H - WN; y += st) begin
      for (int x = 0; x <= W - WN; x += st) begin
        for (int b = 0; b < NB; b++) begin
          e.x = 3'(x);
          e.y = 3'(y);
          e.b = 1'(b);
          e.l = (b == NB - 1) && (x + st > W - WN) && (y + st > H - WN);
          e.d = '0;
          for (int r = 0; r < BR; r++) begin
            for (int c = 0; c < WN; c++) begin
              e.d[(r*WN + c)*PW +: PW] = 8'((y + b*BR + r)*W + x + c);
            end
          end
          q.push_back(e);
        end
      end
    end
  endfunction

  task automatic start(input int s);
    pops = 0;
    dones = 0;
    last_seen = 1'b0;
    init = 1'b1;
    stride = 5'(s);
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_done: got no done, required done within 2000 cycles", nm);
    end
    @(posedge clk);
    #1;
    chk({nm, "_queue_left"}, 64'(q.size()), 64'd0);
    chk({nm, "_rdy_after"}, 64'(rdy), 64'd1);
  endtask

  task automatic wait_vld(input string nm, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_vld) return;
    end
    tests++;
    fails++;
    $display("FAIL %s_vld: got no out_vld, required within 100 cycles", nm);
  endtask

  initial begin
    int n;
    int m;
    bit low;
    bit bad;
    logic [DW-1:0] d0;

    rst = 1'b1;
    init = 1'b0;
    stride = '0;
    out_rdy = 1'b0;
    #3;
    chk("reset_rdy", 64'(rdy), 64'd1);
    chk("reset_outs", {60'd0, out_vld, ram_rd_en, done, out_last}, 64'd0);
    chk("reset_data", out_data, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic scan, stride 2
    out_rdy = 1'b1;
    push_run(2);
    start(2);
    wait_done("basic");
    chk("basic_beats", 64'(pops), 64'd12);
    chk("basic_dones", 64'(dones), 64'd1);
    chk("basic_first", first_data, 64'h0B0A0908_03020100);
    chk("basic_last", last_data, 64'h2F2E2D2C_27262524);

    // non-dividing stride with backpressure on the first beat
    out_rdy = 1'b0;
    push_run(3);
    start(3);
    wait_vld("bp", n);
    d0 = out_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_vld || out_data !== d0 || ram_rd_en) bad = 1;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_data", d0, 64'h0B0A0908_03020100);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    chk("bp_vld_drop", 64'(out_vld), 64'd0);
    chk("bp_refetch", 64'(ram_rd_en), 64'd1);
    wait_vld("bp2", n);
    chk("bp_next_beat", {out_win_x, out_win_y, out_beat}, 64'b000_000_1);
    out_rdy = 1'b1;
    wait_done("stride3");
    chk("stride3_beats", 64'(pops), 64'd4);

    // stride 0 acts as 1
    push_run(0);
    start(0);
    wait_done("stride0");
    chk("stride0_beats", 64'(pops), 64'd30);

    // oversize stride gives a single window
    push_run(31);
    start(31);
    wait_done("stride31");
    chk("stride31_beats", 64'(pops), 64'd2);
    chk("stride31_first", first_data, 64'h0B0A0908_03020100);

    // latency, throughput, init ignored mid-run
    push_run(2);
    start(2);
    wait_vld("lat", n);
    chk("latency", 64'(n), 64'd9);
    m = 0;
    low = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      m++;
      if (!out_vld) low = 1;
      if (low && out_vld) break;
    end
    chk("beat_spacing", 64'(m), 64'd10);
    init = 1'b1;
    stride = 5'd1;
    chk("busy_rdy", 64'(rdy), 64'd0);
    @(posedge clk);
    #1;
    init = 1'b0;
    wait_done("ignored_init");
    chk("ignored_init_beats", 64'(pops), 64'd12);

    // reset during the fetch of the second window
    push_run(2);
    start(2);
    for (int i = 0; i < 200 && pops < 2; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(rdy), 64'd1);
    chk("mid_rst_outs", {60'd0, out_vld, ram_rd_en, done, out_last}, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_pos", {ram_addr, out_win_x, out_win_y, out_beat}, 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_run(2);
    start(2);
    wait_done("restart");
    chk("restart_beats", 64'(pops), 64'd12);
    chk("restart_first", first_data, 64'h0B0A0908_03020100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ipgu_window_scanner.md
Name: ipgu_window_scanner

Overview:
Parametrised successor to the current fixed 300x300 / 20x20 image pyramid generation unit.
- Scans a row-major IMG_W x IMG_H image held in an external synchronous RAM.
- Extracts WIN x WIN windows at a stride programmable per run, in raster order.
- Delivers each window to the heuristic unit (HEU) as WIN/BEAT_ROWS beats of BEAT_ROWS full rows, under a valid/ready handshake.
- Sits between the control unit (start/idle) and the HEU (consumer).

Parameters:
- PIX_W, 8, bits per pixel
- IMG_W, 300, image width in pixels
- IMG_H, 300, image height in pixels
- WIN, 20, window side in pixels; WIN <= IMG_W and WIN <= IMG_H
- BEAT_ROWS, 4, window rows per output beat; WIN % BEAT_ROWS == 0
- STRIDE_W, 5, width of the stride input
- ADDR_W, $clog2(IMG_W*IMG_H), RAM address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- init  in  1  start pulse; accepted only when rdy=1
- stride  in  STRIDE_W  window step in x and y; sampled on accepted init; 0 is treated as 1
- rdy  out  1  idle, ready for init
- ram_rd_en  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM address, y*IMG_W+x
- ram_rd_data  in  PIX_W  RAM data, valid 1 cycle after ram_rd_en
- out_rdy  in  1  HEU ready
- out_vld  out  1  beat valid
- out_data  out  BEAT_ROWS*WIN*PIX_W  beat; pixel (r,c) at [(r*WIN+c)*PIX_W +: PIX_W]
- out_beat  out  $clog2(WIN/BEAT_ROWS) (min 1)  beat index within window
- out_win_x  out  $clog2(IMG_W)  window top-left x
- out_win_y  out  $clog2(IMG_H)  window top-left y
- out_last  out  1  final beat of final window
- done  out  1  one-cycle pulse, run complete

Behaviour:
- Reset (async, any state): state=IDLE; all counters 0; buffer, out_data 0; out_vld, ram_rd_en, done, out_last 0; ram_addr 0; rdy=1 (rdy = state==IDLE).
- States: IDLE -> FETCH -> WAIT_RD -> PRESENT -> (FETCH | DONE) -> IDLE.
- IDLE: on init, latch stride (0 -> 1); set win_x=win_y=beat=0; go to FETCH. init in any other state is ignored.
- FETCH: issues BEAT_ROWS*WIN reads on consecutive cycles, row-major within the beat. Address = (win_y + beat*BEAT_ROWS + r)*IMG_W + win_x + c. Each ram_rd_data is written to buffer slot (r,c) one cycle after its read. After the last read, go to WAIT_RD.
- WAIT_RD: captures the final pixel, goes to PRESENT.
- Latency: out_vld rises BEAT_ROWS*WIN+1 cycles after FETCH entry.
- PRESENT: out_vld=1. out_data, out_beat, out_win_x, out_win_y, out_last stay stable until out_vld&&out_rdy. No RAM reads occur.
- On handshake, advance in this priority:
  - beat++ if not the last beat;
  - else beat=0 and win_x+=stride if win_x+stride <= IMG_W-WIN;
  - else win_x=0 and win_y+=stride if win_y+stride <= IMG_H-WIN;
  - else go to DONE.
  - Otherwise go to FETCH, with out_vld=0 the next cycle.
- Window positions never exceed IMG_W-WIN / IMG_H-WIN. Trailing pixels not reachable by the stride are skipped; there is no clamping.
- out_last = 1 in PRESENT on the final beat of the final window.
- DONE: done=1 for one cycle, then IDLE (rdy=1 the following cycle).
- out_rdy held high: next FETCH starts the cycle after the handshake, with no bubble beyond the fetch latency.
- out_rdy asserted outside PRESENT: no effect.
- All arithmetic is unsigned. Address math uses ADDR_W+1 bits internally and is truncated to ADDR_W.
- stride > IMG_W-WIN and > IMG_H-WIN: exactly one window at (0,0).
- Reset mid-run abandons the run. done is not asserted. The HEU must discard any partial window.

Test Plan:
- Basic scan. IMG_W=8, IMG_H=6, WIN=4, BEAT_ROWS=2; RAM[a]=a; stride=2.
  -> 6 windows in order (0,0),(2,0),(4,0),(0,2),(2,2),(4,2); 12 beats.
  -> First beat pixels 0,1,2,3,8,9,10,11.
  -> Beat 1 of window (4,2): pixels 36..39, 44..47.
  -> out_last only on the 12th beat; done 1 cycle later.
- Non-dividing stride. Same image, stride=3.
  -> Windows (0,0),(3,0) only; 4 beats; done.
- Stride 0 and oversize stride.
  -> stride=0 behaves as stride=1: 15 windows.
  -> stride=31: 1 window at (0,0).
- Backpressure. out_rdy low 10 cycles during PRESENT.
  -> out_vld and out_data stable.
  -> No ram_rd_en.
  -> Advance exactly one beat after out_rdy rises.
- Latency and throughput. out_rdy tied high.
  -> First out_vld 9 cycles after FETCH entry (2*4+1).
  -> Consecutive beats spaced by 10 cycles.
  -> init during run ignored.
- Reset mid-run. Assert rst during FETCH of window 2.
  -> All outputs 0 and rdy=1 immediately (async).
  -> New init restarts at (0,0) with correct data.
